// File: rtl/cve2_rf_dualwr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cve2_pkg
// Purpose  : Shared types and constants for the dual-write register file.
// Revision : 1.0
// ============================================================================
package cve2_pkg;

  localparam int RF_ADDR_W     = 5;
  localparam int RF_NUM_REGS_I = 32;
  localparam int RF_NUM_REGS_E = 16;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  typedef enum logic {
    RF_PORT_A = 1'b0,
    RF_PORT_B = 1'b1
  } rf_port_e;

  // On a same-address double write, port A's data is the one committed.
  localparam rf_port_e RF_WR_PRIO_A = RF_PORT_A;

endpackage
`default_nettype wire

// File: rtl/cve2_rf_dualwr_if.sv
`default_nettype none
// ============================================================================
// Module   : cve2_rf_dualwr_if
// Purpose  : Read/write/status bundle between ID/writeback and the register file.
// Revision : 1.0
// ============================================================================
interface cve2_rf_dualwr_if #(
  parameter int DataWidth = 32
);
  import cve2_pkg::*;

  rf_addr_t             raddr_a_i;
  logic [DataWidth-1:0] rdata_a_o;
  rf_addr_t             raddr_b_i;
  logic [DataWidth-1:0] rdata_b_o;

  rf_addr_t             waddr_a_i;
  logic [DataWidth-1:0] wdata_a_i;
  logic                 we_a_i;
  rf_addr_t             waddr_b_i;
  logic [DataWidth-1:0] wdata_b_i;
  logic                 we_b_i;

  logic                 clr_status_i;
  logic                 wr_collision_o;
  logic                 addr_err_o;

  modport master (
    output raddr_a_i, raddr_b_i,
    output waddr_a_i, wdata_a_i, we_a_i,
    output waddr_b_i, wdata_b_i, we_b_i,
    output clr_status_i,
    input  rdata_a_o, rdata_b_o,
    input  wr_collision_o, addr_err_o
  );

  modport slave (
    input  raddr_a_i, raddr_b_i,
    input  waddr_a_i, wdata_a_i, we_a_i,
    input  waddr_b_i, wdata_b_i, we_b_i,
    input  clr_status_i,
    output rdata_a_o, rdata_b_o,
    output wr_collision_o, addr_err_o
  );

endinterface
`default_nettype wire

// File: rtl/cve2_rf_dualwr_wr_decode.sv
`default_nettype none
// ============================================================================
// Module   : cve2_rf_wr_decode
// Purpose  : One write port's address -> one-hot register enable, x0 never set.
// Revision : 1.0
// ============================================================================
module cve2_rf_wr_decode
  import cve2_pkg::*;
#(
  parameter bit RV32E   = 1'b0,
  parameter int NumRegs = RV32E ? RF_NUM_REGS_E : RF_NUM_REGS_I
) (
  input  rf_addr_t           addr_i,
  input  logic               en_i,
  output logic [NumRegs-1:0] we_onehot_o,
  output logic               addr_err_o
);

  // Addresses beyond NumRegs match no k, so RV32E writes with bit 4 set drop here.
  always_comb begin
    we_onehot_o = '0;
    for (int k = 1; k < NumRegs; k++) begin
      we_onehot_o[k] = en_i & (addr_i == rf_addr_t'(k));
    end
  end

  assign addr_err_o = en_i & RV32E & addr_i[RF_ADDR_W-1];

endmodule
`default_nettype wire

// File: rtl/cve2_rf_dualwr.sv
`default_nettype none
// ============================================================================
// Module   : cve2_rf_dualwr
// Purpose  : Two-write/two-read integer register file with sticky status flags.
//            Build macro CVE2_RF_WRITE_BYPASS_EN adds same-cycle write forwarding.
// Revision : 1.0
// ============================================================================
module cve2_rf_dualwr
  import cve2_pkg::*;
#(
  parameter bit                   RV32E       = 1'b0,
  parameter int                   DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cve2_rf_dualwr_if.slave  bus
);

  localparam int NumRegs = RV32E ? RF_NUM_REGS_E : RF_NUM_REGS_I;

  logic [NumRegs-1:0]   we_a_vec;
  logic [NumRegs-1:0]   we_b_vec;
  logic                 wr_err_a;
  logic                 wr_err_b;
  logic                 unused_we0;

  logic [DataWidth-1:0] rf_q   [1:NumRegs-1];
  logic [DataWidth-1:0] rf_d   [1:NumRegs-1];
  logic [DataWidth-1:0] rd_src [1:NumRegs-1];
  logic [DataWidth-1:0] rdata_a;
  logic [DataWidth-1:0] rdata_b;

  logic                 coll_evt;
  logic                 rd_err;
  logic                 aerr_evt;
  logic                 wr_coll_q, wr_coll_d;
  logic                 addr_err_q, addr_err_d;

  cve2_rf_wr_decode #(
    .RV32E   (RV32E),
    .NumRegs (NumRegs)
  ) u_dec_a (
    .addr_i      (bus.waddr_a_i),
    .en_i        (bus.we_a_i),
    .we_onehot_o (we_a_vec),
    .addr_err_o  (wr_err_a)
  );

  cve2_rf_wr_decode #(
    .RV32E   (RV32E),
    .NumRegs (NumRegs)
  ) u_dec_b (
    .addr_i      (bus.waddr_b_i),
    .en_i        (bus.we_b_i),
    .we_onehot_o (we_b_vec),
    .addr_err_o  (wr_err_b)
  );

  assign unused_we0 = we_a_vec[0] | we_b_vec[0];

  always_comb begin
    rf_d = rf_q;
    for (int k = 1; k < NumRegs; k++) begin
      if (we_a_vec[k]) begin
        rf_d[k] = bus.wdata_a_i;
      end else if (we_b_vec[k]) begin
        rf_d[k] = bus.wdata_b_i;
      end
    end
  end

`ifdef CVE2_RF_WRITE_BYPASS_EN
  // Next-state already holds the A-over-B merged write data: forwarding is free.
  assign rd_src = rf_d;
`else
  assign rd_src = rf_q;
`endif

  always_comb begin
    rdata_a = WordZeroVal;
    rdata_b = WordZeroVal;
    for (int k = 1; k < NumRegs; k++) begin
      if (bus.raddr_a_i == rf_addr_t'(k)) begin
        rdata_a = rd_src[k];
      end
      if (bus.raddr_b_i == rf_addr_t'(k)) begin
        rdata_b = rd_src[k];
      end
    end
  end

  assign bus.rdata_a_o = rdata_a;
  assign bus.rdata_b_o = rdata_b;

  assign coll_evt = bus.we_a_i & bus.we_b_i
                  & (bus.waddr_a_i == bus.waddr_b_i)
                  & (bus.waddr_a_i != '0);
  assign rd_err   = RV32E & (bus.raddr_a_i[RF_ADDR_W-1] | bus.raddr_b_i[RF_ADDR_W-1]);
  assign aerr_evt = wr_err_a | wr_err_b | rd_err;

  // A fresh event outranks a simultaneous clear.
  assign wr_coll_d  = coll_evt | (wr_coll_q & ~bus.clr_status_i);
  assign addr_err_d = aerr_evt | (addr_err_q & ~bus.clr_status_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 1; k < NumRegs; k++) begin
        rf_q[k] <= WordZeroVal;
      end
      wr_coll_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rf_q       <= rf_d;
      wr_coll_q  <= wr_coll_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.wr_collision_o = wr_coll_q;
  assign bus.addr_err_o     = addr_err_q;

  a_coll_has_cause: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $rose(bus.wr_collision_o) |-> $past(coll_evt)
  );

  a_x0_read_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (bus.raddr_a_i == '0) |-> (bus.rdata_a_o == WordZeroVal)
  );

  a_x0_read_b: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (bus.raddr_b_i == '0) |-> (bus.rdata_b_o == WordZeroVal)
  );

endmodule
`default_nettype wire

// File: tb/tb_cve2_rf_dualwr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cve2_rf_dualwr
// Purpose  : Self-checking bench driving an RV32I and an RV32E instance in lockstep.
// Revision : 1.0
// ============================================================================
module tb_cve2_rf_dualwr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_we_a, t_we_b, t_clr;
  logic [4:0]  t_wa, t_wb, t_ra, t_rb;
  logic [31:0] t_da, t_db;

  cve2_rf_dualwr_if #(.DataWidth(32)) if_i ();
  cve2_rf_dualwr_if #(.DataWidth(32)) if_e ();

  assign if_i.we_a_i = t_we_a;  assign if_e.we_a_i = t_we_a;
  assign if_i.we_b_i = t_we_b;  assign if_e.we_b_i = t_we_b;
  assign if_i.waddr_a_i = t_wa; assign if_e.waddr_a_i = t_wa;
  assign if_i.waddr_b_i = t_wb; assign if_e.waddr_b_i = t_wb;
  assign if_i.wdata_a_i = t_da; assign if_e.wdata_a_i = t_da;
  assign if_i.wdata_b_i = t_db; assign if_e.wdata_b_i = t_db;
  assign if_i.raddr_a_i = t_ra; assign if_e.raddr_a_i = t_ra;
  assign if_i.raddr_b_i = t_rb; assign if_e.raddr_b_i = t_rb;
  assign if_i.clr_status_i = t_clr; assign if_e.clr_status_i = t_clr;

  cve2_rf_dualwr #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0)) u_dut_i (
    .clk_i (clk), .rst_ni (rst_n), .bus (if_i)
  );
  cve2_rf_dualwr #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0)) u_dut_e (
    .clk_i (clk), .rst_ni (rst_n), .bus (if_e)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: architectural register contents per instance (0 = RV32I, 1 = RV32E).
  logic [31:0] m_mem [2][32];
  bit          m_coll [2];
  bit          m_aerr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 32; k++) m_mem[d][k] = 32'h0;
      m_coll[d] = 1'b0;
      m_aerr[d] = 1'b0;
    end
  endtask

  function automatic bit in_range(int d, logic [4:0] a);
    return (d == 0) || (a < 5'd16);
  endfunction

  function automatic logic [31:0] exp_read(int d, logic [4:0] ra);
    if (ra == 5'd0 || !in_range(d, ra)) return 32'h0;
`ifdef CVE2_RF_WRITE_BYPASS_EN
    if (t_we_a && t_wa == ra) return t_da;
    if (t_we_b && t_wb == ra) return t_db;
`endif
    return m_mem[d][ra];
  endfunction

  task automatic model_commit();
    bit coll, aerr;
    for (int d = 0; d < 2; d++) begin
      coll = t_we_a && t_we_b && (t_wa == t_wb) && (t_wa != 5'd0);
      aerr = (d == 1) && ((t_we_a && t_wa >= 5'd16) || (t_we_b && t_wb >= 5'd16) ||
                          t_ra >= 5'd16 || t_rb >= 5'd16);
      if (t_we_b && t_wb != 5'd0 && in_range(d, t_wb)) m_mem[d][t_wb] = t_db;
      if (t_we_a && t_wa != 5'd0 && in_range(d, t_wa)) m_mem[d][t_wa] = t_da;
      m_coll[d] = coll || (m_coll[d] && !t_clr);
      m_aerr[d] = aerr || (m_aerr[d] && !t_clr);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " I rdata_a"}, if_i.rdata_a_o, exp_read(0, t_ra));
    chk({tag, " I rdata_b"}, if_i.rdata_b_o, exp_read(0, t_rb));
    chk({tag, " I coll"}, 32'(if_i.wr_collision_o), 32'(m_coll[0]));
    chk({tag, " I aerr"}, 32'(if_i.addr_err_o), 32'(m_aerr[0]));
    chk({tag, " E rdata_a"}, if_e.rdata_a_o, exp_read(1, t_ra));
    chk({tag, " E rdata_b"}, if_e.rdata_b_o, exp_read(1, t_rb));
    chk({tag, " E coll"}, 32'(if_e.wr_collision_o), 32'(m_coll[1]));
    chk({tag, " E aerr"}, 32'(if_e.addr_err_o), 32'(m_aerr[1]));
  endtask

  task automatic drive(input logic wea, input logic [4:0] wa, input logic [31:0] da,
                       input logic web, input logic [4:0] wb, input logic [31:0] db,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    t_we_a = wea; t_wa = wa; t_da = da;
    t_we_b = web; t_wb = wb; t_db = db;
    t_ra = ra; t_rb = rb; t_clr = clr;
  endtask

  // Called shortly after a falling edge with inputs applied; ends at the next falling edge.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst I coll", 32'(if_i.wr_collision_o), 32'h0);
    chk("rst I aerr", 32'(if_i.addr_err_o), 32'h0);
    chk("rst E coll", 32'(if_e.wr_collision_o), 32'h0);
    chk("rst E aerr", 32'(if_e.addr_err_o), 32'h0);

    for (int k = 0; k < 32; k++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(k), 5'(31 - k), 0);
      #1;
      chk("sweep I a", if_i.rdata_a_o, 32'h0);
      chk("sweep E b", if_e.rdata_b_o, 32'h0);
      step("sweep");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("clr0");

    drive(1, 5, 32'hDEADBEEF, 1, 9, 32'h12345678, 0, 0, 0);
    step("wr5_9");
    drive(0, 0, 0, 0, 0, 0, 5, 9, 0);
    #1;
    chk("x5 I", if_i.rdata_a_o, 32'hDEADBEEF);
    chk("x9 E", if_e.rdata_b_o, 32'h12345678);
    chk("no coll 5_9", 32'(if_i.wr_collision_o), 32'h0);
    step("rd5_9");

    drive(1, 7, 32'hAAAA0001, 1, 7, 32'hBBBB0002, 0, 0, 0);
    step("wr7_7");
    drive(0, 0, 0, 0, 0, 0, 7, 7, 0);
    #1;
    chk("x7 A wins", if_i.rdata_a_o, 32'hAAAA0001);
    chk("coll set I", 32'(if_i.wr_collision_o), 32'h1);
    chk("coll set E", 32'(if_e.wr_collision_o), 32'h1);
    step("rd7");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("clr1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("coll cleared", 32'(if_i.wr_collision_o), 32'h0);
    step("after clr1");

    drive(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 1);
    step("coll+clr");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("event beats clr", 32'(if_i.wr_collision_o), 32'h1);
    step("after coll+clr");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("clr2");

    drive(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    step("wr x0");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0 reads 0", if_i.rdata_a_o, 32'h0);
    chk("x0 no coll", 32'(if_i.wr_collision_o), 32'h0);
    step("rd x0");

    drive(1, 20, 32'h55, 0, 0, 0, 0, 0, 0);
    step("wr20");
    drive(0, 0, 0, 0, 0, 0, 20, 0, 0);
    #1;
    chk("x20 I", if_i.rdata_a_o, 32'h55);
    chk("x20 E dropped", if_e.rdata_a_o, 32'h0);
    chk("aerr E", 32'(if_e.addr_err_o), 32'h1);
    chk("aerr I", 32'(if_i.addr_err_o), 32'h0);
    step("rd20");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("clr3");

    drive(1, 3, 32'h0F0F, 0, 0, 0, 3, 0, 0);
    #1;
`ifdef CVE2_RF_WRITE_BYPASS_EN
    chk("x3 same cycle", if_i.rdata_a_o, 32'h0F0F);
`else
    chk("x3 same cycle", if_i.rdata_a_o, 32'h0);
`endif
    step("wr3");
    drive(0, 0, 0, 0, 0, 0, 3, 0, 0);
    #1;
    chk("x3 next cycle", if_e.rdata_a_o, 32'h0F0F);
    step("rd3");

    drive(1, 5, 32'h11112222, 1, 6, 32'h33334444, 5, 6, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 5, 6, 0);
    #1;
    chk("rst discards x5", if_i.rdata_a_o, 32'h0);
    chk("rst discards x6", if_e.rdata_b_o, 32'h0);
    step("after mid reset");

    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, wb, ra, rb;
      wa = 5'($urandom_range(0, 31));
      wb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 15));
      rb = ($urandom_range(0, 4) == 0) ? wb : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom(),
            1'($urandom_range(0, 1)), wb, $urandom(),
            ra, rb, 1'($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
